// File: rtl/csr_write_arbiter.sv
// CSR bank write arbiter (pipeline vs debug, round-robin) with shadow-mismatch error capture.
// Build option CV32E41S_CSR_SCAN_EN: periodic one-lane scanner; otherwise all flags are OR-reduced every cycle.
module csr_write_arbiter #(
   parameter int NUM_CSR       = 8,
   parameter int WIDTH         = 32,
   parameter int SCAN_INTERVAL = 16,
   parameter int AW            = $clog2(NUM_CSR)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pipe_req_i,
   input  logic [AW-1:0]      pipe_addr_i,
   input  logic [WIDTH-1:0]   pipe_wdata_i,
   output logic               pipe_gnt_o,
   input  logic               dbg_req_i,
   input  logic [AW-1:0]      dbg_addr_i,
   input  logic [WIDTH-1:0]   dbg_wdata_i,
   output logic               dbg_gnt_o,
   output logic [NUM_CSR-1:0] csr_wr_en_o,
   output logic [WIDTH-1:0]   csr_wr_data_o,
   input  logic [NUM_CSR-1:0] csr_rd_error_i,
   output logic               addr_err_o,
   output logic               err_valid_o,
   output logic [AW-1:0]      err_idx_o,
   output logic               alert_major_o,
   input  logic               err_clear_i
);

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] wdata;
   } wr_req_t;

   logic               rr_dbg;
   logic               any_gnt;
   logic               in_range;
   wr_req_t            sel_req;
   logic [NUM_CSR-1:0] dec;

   // rr_dbg=1 means debug wins the next contest
   assign dbg_gnt_o  = dbg_req_i  & (~pipe_req_i | rr_dbg);
   assign pipe_gnt_o = pipe_req_i & (~dbg_req_i  | ~rr_dbg);
   assign any_gnt    = dbg_gnt_o | pipe_gnt_o;

   assign sel_req  = dbg_gnt_o ? wr_req_t'{dbg_addr_i, dbg_wdata_i}
                               : wr_req_t'{pipe_addr_i, pipe_wdata_i};
   assign in_range = (32'(sel_req.addr) < NUM_CSR);

   for (genvar g = 0; g < NUM_CSR; g++) begin : g_dec
      assign dec[g] = (sel_req.addr == AW'(g));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_dbg <= 1'b1;
      end else if (pipe_req_i && dbg_req_i) begin
         rr_dbg <= ~rr_dbg;
      end
   end

   // Out-of-range writes are granted but leave the bank and the data bus alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csr_wr_en_o   <= '0;
         csr_wr_data_o <= '0;
         addr_err_o    <= 1'b0;
      end else if (any_gnt) begin
         csr_wr_en_o <= dec;
         addr_err_o  <= ~in_range;
         if (in_range) csr_wr_data_o <= sel_req.wdata;
      end else begin
         csr_wr_en_o <= '0;
         addr_err_o  <= 1'b0;
      end
   end

   logic          hit;
   logic [AW-1:0] hit_idx;

`ifdef CV32E41S_CSR_SCAN_EN
   localparam int CW = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;

   logic [CW-1:0] scan_cnt;
   logic [AW-1:0] scan_idx;
   logic          scan_tick;
   logic          scan_flag;

   assign scan_tick = (32'(scan_cnt) == SCAN_INTERVAL - 1);

   always_comb begin
      scan_flag = 1'b0;
      for (int i = 0; i < NUM_CSR; i++) begin
         if (scan_idx == AW'(i)) scan_flag = csr_rd_error_i[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_tick) begin
         scan_cnt <= '0;
         scan_idx <= (32'(scan_idx) == NUM_CSR - 1) ? '0 : scan_idx + AW'(1);
      end else begin
         scan_cnt <= scan_cnt + CW'(1);
      end
   end

   assign hit     = scan_tick & scan_flag;
   assign hit_idx = scan_idx;
`else
   assign hit = |csr_rd_error_i;

   // Descending walk so the lowest set flag is the last assignment
   always_comb begin
      hit_idx = '0;
      for (int i = NUM_CSR - 1; i >= 0; i--) begin
         if (csr_rd_error_i[i]) hit_idx = AW'(i);
      end
   end
`endif

   // A new error beats a simultaneous clear and reloads the index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alert_major_o <= 1'b0;
         err_valid_o   <= 1'b0;
         err_idx_o     <= '0;
      end else begin
         alert_major_o <= hit;
         if (hit && (!err_valid_o || err_clear_i)) begin
            err_valid_o <= 1'b1;
            err_idx_o   <= hit_idx;
         end else if (err_clear_i) begin
            err_valid_o <= 1'b0;
            err_idx_o   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_csr_write_arbiter.sv
// Directed bench for csr_write_arbiter: arbitration, write issue, address errors, reset, error capture.
module tb_csr_write_arbiter;

   localparam int NUM_CSR = 8;
   localparam int WIDTH   = 32;
   localparam int SI      = 4;
   localparam int AW      = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               pipe_req_i, dbg_req_i, err_clear_i;
   logic [AW-1:0]      pipe_addr_i, dbg_addr_i;
   logic [WIDTH-1:0]   pipe_wdata_i, dbg_wdata_i;
   logic               pipe_gnt_o, dbg_gnt_o;
   logic [NUM_CSR-1:0] csr_wr_en_o, csr_rd_error_i;
   logic [WIDTH-1:0]   csr_wr_data_o;
   logic               addr_err_o, err_valid_o, alert_major_o;
   logic [AW-1:0]      err_idx_o;

   int n_cmp = 0;
   int n_err = 0;

   csr_write_arbiter #(.NUM_CSR(NUM_CSR), .WIDTH(WIDTH), .SCAN_INTERVAL(SI), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_req_i(pipe_req_i), .pipe_addr_i(pipe_addr_i), .pipe_wdata_i(pipe_wdata_i),
      .pipe_gnt_o(pipe_gnt_o),
      .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
      .dbg_gnt_o(dbg_gnt_o),
      .csr_wr_en_o(csr_wr_en_o), .csr_wr_data_o(csr_wr_data_o),
      .csr_rd_error_i(csr_rd_error_i), .addr_err_o(addr_err_o),
      .err_valid_o(err_valid_o), .err_idx_o(err_idx_o),
      .alert_major_o(alert_major_o), .err_clear_i(err_clear_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_wr(input string tag, input logic [7:0] en, input logic [31:0] data,
                         input logic aerr);
      chk({tag, "_en"}, 64'(csr_wr_en_o), 64'(en));
      chk({tag, "_data"}, 64'(csr_wr_data_o), 64'(data));
      chk({tag, "_aerr"}, 64'(addr_err_o), 64'(aerr));
   endtask

   task automatic chk_gnt(input string tag, input logic pg, input logic dg);
      #1;
      chk({tag, "_pgnt"}, 64'(pipe_gnt_o), 64'(pg));
      chk({tag, "_dgnt"}, 64'(dbg_gnt_o), 64'(dg));
   endtask

   task automatic chk_err(input string tag, input logic al, input logic v, input logic [3:0] idx);
      chk({tag, "_alert"}, 64'(alert_major_o), 64'(al));
      chk({tag, "_valid"}, 64'(err_valid_o), 64'(v));
      chk({tag, "_idx"}, 64'(err_idx_o), 64'(idx));
   endtask

   initial begin
      rst_n = 1'b0;
      pipe_req_i = 1'b0; pipe_addr_i = '0; pipe_wdata_i = '0;
      dbg_req_i  = 1'b0; dbg_addr_i  = '0; dbg_wdata_i  = '0;
      csr_rd_error_i = '0; err_clear_i = 1'b0;
      tick(); tick();

      // Reset state, and grant is combinational while reset is held
      chk_wr("rst", 8'h00, 32'h0, 1'b0);
      chk_err("rst", 1'b0, 1'b0, 4'd0);
      pipe_req_i = 1'b1;
      chk_gnt("rst_comb", 1'b1, 1'b0);
      pipe_req_i = 1'b0;
      rst_n = 1'b1;

      // Contested requests: dbg, pipe, dbg, pipe
      pipe_req_i = 1'b1; pipe_addr_i = 4'd1; pipe_wdata_i = 32'hA1;
      dbg_req_i  = 1'b1; dbg_addr_i  = 4'd2; dbg_wdata_i  = 32'hD2;
      chk_gnt("rr1", 1'b0, 1'b1);
      tick();
      chk_wr("rr1", 8'b0000_0100, 32'hD2, 1'b0);
      dbg_addr_i = 4'd4; dbg_wdata_i = 32'hD4;
      chk_gnt("rr2", 1'b1, 1'b0);
      tick();
      chk_wr("rr2", 8'b0000_0010, 32'hA1, 1'b0);
      pipe_addr_i = 4'd5; pipe_wdata_i = 32'hA5;
      chk_gnt("rr3", 1'b0, 1'b1);
      tick();
      chk_wr("rr3", 8'b0001_0000, 32'hD4, 1'b0);
      chk_gnt("rr4", 1'b1, 1'b0);
      tick();
      chk_wr("rr4", 8'b0010_0000, 32'hA5, 1'b0);
      pipe_req_i = 1'b0; dbg_req_i = 1'b0;
      tick();
      chk_wr("idle", 8'h00, 32'hA5, 1'b0);

      // Single uncontested pipe write; data holds afterwards
      pipe_req_i = 1'b1; pipe_addr_i = 4'd3; pipe_wdata_i = 32'hDEADBEEF;
      chk_gnt("single", 1'b1, 1'b0);
      tick();
      pipe_req_i = 1'b0;
      chk_wr("single", 8'b0000_1000, 32'hDEADBEEF, 1'b0);
      tick();
      chk_wr("single_hold", 8'h00, 32'hDEADBEEF, 1'b0);

      // Uncontested grant must not move the pointer: debug still wins
      pipe_req_i = 1'b1; pipe_addr_i = 4'd6; pipe_wdata_i = 32'h66;
      dbg_req_i  = 1'b1; dbg_addr_i  = 4'd0; dbg_wdata_i  = 32'h0BADF00D;
      chk_gnt("rr_keep", 1'b0, 1'b1);
      tick();
      pipe_req_i = 1'b0; dbg_req_i = 1'b0;
      chk_wr("rr_keep", 8'b0000_0001, 32'h0BADF00D, 1'b0);

      // Out-of-range addresses 9 (dbg) and 8 (pipe)
      dbg_req_i = 1'b1; dbg_addr_i = 4'd9; dbg_wdata_i = 32'h12345678;
      chk_gnt("oor9", 1'b0, 1'b1);
      tick();
      dbg_req_i = 1'b0;
      chk_wr("oor9", 8'h00, 32'h0BADF00D, 1'b1);
      pipe_req_i = 1'b1; pipe_addr_i = 4'd8; pipe_wdata_i = 32'h88888888;
      tick();
      pipe_req_i = 1'b0;
      chk_wr("oor8", 8'h00, 32'h0BADF00D, 1'b1);
      tick();
      chk_wr("oor_done", 8'h00, 32'h0BADF00D, 1'b0);

      // Reset pulse between grant and the issuing edge drops the write
      pipe_req_i = 1'b1; pipe_addr_i = 4'd7; pipe_wdata_i = 32'h77;
      chk_gnt("midrst", 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1 pipe_req_i = 1'b0;
      rst_n = 1'b1;
      tick();
      chk_wr("midrst", 8'h00, 32'h0, 1'b0);
      chk_err("midrst", 1'b0, 1'b0, 4'd0);

      // Error capture from a fresh reset
      rst_n = 1'b0;
      tick();
`ifdef CV32E41S_CSR_SCAN_EN
      csr_rd_error_i = 8'b0000_0100;
      rst_n = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         chk("scan_quiet_alert", 64'(alert_major_o), 64'd0);
      end
      tick();
      chk_err("scan_hit2", 1'b1, 1'b1, 4'd2);
      csr_rd_error_i = 8'b0010_0000;
      tick();
      chk_err("scan_post2", 1'b0, 1'b1, 4'd2);
      for (int k = 14; k <= 23; k++) tick();
      chk_err("scan_pre5", 1'b0, 1'b1, 4'd2);
      err_clear_i = 1'b1;
      tick();
      err_clear_i = 1'b0; csr_rd_error_i = '0;
      chk_err("clr_collide", 1'b1, 1'b1, 4'd5);
      tick();
      err_clear_i = 1'b1;
      tick();
      err_clear_i = 1'b0;
      chk_err("clr_alone", 1'b0, 1'b0, 4'd0);
`else
      csr_rd_error_i = 8'b0100_0010;
      rst_n = 1'b1;
      tick();
      chk_err("or_hit1", 1'b1, 1'b1, 4'd1);
      tick();
      chk_err("or_hit2", 1'b1, 1'b1, 4'd1);
      tick();
      chk("or_hit3_alert", 64'(alert_major_o), 64'd1);
      csr_rd_error_i = '0;
      tick();
      chk_err("or_quiet", 1'b0, 1'b1, 4'd1);
      csr_rd_error_i = 8'b0010_0000; err_clear_i = 1'b1;
      tick();
      csr_rd_error_i = '0;
      chk_err("clr_collide", 1'b1, 1'b1, 4'd5);
      tick();
      chk_err("clr_nohit", 1'b0, 1'b0, 4'd0);
      csr_rd_error_i = 8'b0000_1000;
      tick();
      err_clear_i = 1'b0; csr_rd_error_i = '0;
      chk_err("set_idx3", 1'b1, 1'b1, 4'd3);
      err_clear_i = 1'b1;
      tick();
      err_clear_i = 1'b0;
      chk_err("clr_alone", 1'b0, 1'b0, 4'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
